// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   (if_*) and the data load/store requester (dm_*). One transaction is in
//   flight at a time. Ties are broken round-robin against the last granted
//   requester. A watchdog ends any access that the memory never acknowledges.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request        -> if_gnt (grant pulse)
//   if_rvalid/if_rdata/if_err  fetch response pulse, data, timeout flag
//   dm_req/we/be/addr/wdata    data request         -> dm_gnt (grant pulse)
//   dm_rvalid/dm_rdata/dm_err  data response pulse, load data, timeout flag
//   mem_req/we/be/addr/wdata   memory access, driven only while BUSY
//   mem_ready/mem_rdata        memory completion and read data
//   busy                       high while an access or response is pending
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    // Keep the counter at least one bit wide when the watchdog is disabled.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_err_q, if_err_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          dm_err_q, dm_err_d;

    logic grant_if, grant_dm, timed_out;

    // Grants are combinational and gated by rst_n so none escapes during reset.
    always_comb begin
        grant_if  = rst_n && (state_q == S_IDLE) && if_req && (!dm_req || (last_q == OWN_DM));
        grant_dm  = rst_n && (state_q == S_IDLE) && dm_req && (!if_req || (last_q == OWN_IF));
        timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        if_err_d   = if_err_q;
        dm_rdata_d = dm_rdata_q;
        dm_err_d   = dm_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_dm) begin
                    owner_d = OWN_DM;
                    last_d  = OWN_DM;
                    we_d    = dm_we;
                    be_d    = dm_we ? dm_be : 4'hF;
                    addr_d  = dm_addr;
                    wdata_d = dm_we ? dm_wdata : '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Ready takes priority over the watchdog in the final cycle.
                if (mem_ready || timed_out) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = (mem_ready && !we_q) ? mem_rdata : '0;
                        dm_err_d   = !mem_ready;
                    end else begin
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                        if_err_d   = !mem_ready;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            dm_rdata_q <= '0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            dm_rdata_q <= dm_rdata_d;
            dm_err_q   <= dm_err_d;
        end
    end

    always_comb begin
        if_gnt    = grant_if;
        dm_gnt    = grant_dm;
        mem_req   = (state_q == S_BUSY);
        mem_we    = mem_req & we_q;
        mem_be    = mem_req ? be_q : '0;
        mem_addr  = mem_req ? addr_q : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
        dm_rvalid = (state_q == S_RESP) && (owner_q == OWN_DM);
        if_rdata  = if_rdata_q;
        if_err    = if_err_q;
        dm_rdata  = dm_rdata_q;
        dm_err    = dm_err_q;
        busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (TIMEOUT = 4). Expected responses are queued
// when a grant is seen and popped when a response pulse appears.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic        dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Drive point: just after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic is_dm, input logic [31:0] d, input logic err);
        exp_t e;
        e.is_dm = is_dm;
        e.rdata = d;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Sample point: falling edge; any response pulse is matched to the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0)) begin
            checks++;
            if (if_rvalid === 1'b1 && dm_rvalid === 1'b1) begin
                errors++;
                $display("FAIL rvalid_onehot got if=1 dm=1 required at most one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected got if=%b dm=%b required no response", if_rvalid, dm_rvalid);
            end else begin
                e = sb.pop_front();
                if (dm_rvalid !== e.is_dm) begin
                    errors++;
                    $display("FAIL resp_owner got dm_rvalid=%b required %b", dm_rvalid, e.is_dm);
                end else begin
                    checks++;
                    if ((e.is_dm ? dm_rdata : if_rdata) !== e.rdata) begin
                        errors++;
                        $display("FAIL resp_rdata got %h required %h", e.is_dm ? dm_rdata : if_rdata, e.rdata);
                    end
                    checks++;
                    if ((e.is_dm ? dm_err : if_err) !== e.err) begin
                        errors++;
                        $display("FAIL resp_err got %b required %b", e.is_dm ? dm_err : if_err, e.err);
                    end
                end
            end
        end
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        sb.delete();
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_err, dm_err, mem_req, mem_we, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000000",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_err, dm_err, mem_req, mem_we, busy});
        end
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata, mem_be} !== 132'b0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h %h required all zero",
                     if_rdata, dm_rdata, mem_addr, mem_wdata, mem_be);
        end
        nxt();
        clear_inputs();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b required 0", busy); end
    endtask

    task automatic test_fetch();
        nxt(); if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        checks++;
        if ({if_gnt, dm_gnt, mem_req} !== 3'b100) begin
            errors++; $display("FAIL fetch_gnt got %b required 100", {if_gnt, dm_gnt, mem_req});
        end
        expect_resp(1'b0, 32'h0010_0093, 1'b0);
        nxt(); if_req = 1'b0; if_addr = '0;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be, busy} !== 7'b1011111 || mem_addr !== 32'h10 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL fetch_mem_c1 got req=%b we=%b be=%h busy=%b addr=%h wd=%h required 1 0 f 1 00000010 00000000",
                     mem_req, mem_we, mem_be, busy, mem_addr, mem_wdata);
        end
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL fetch_mem_c2 got req=%b addr=%h required 1 00000010", mem_req, mem_addr);
        end
        nxt(); mem_ready = 1'b0; mem_rdata = '0;
        tick();
        checks++;
        if ({if_rvalid, dm_rvalid, mem_req, busy} !== 4'b1001) begin
            errors++; $display("FAIL fetch_resp_c3 got %b required 1001", {if_rvalid, dm_rvalid, mem_req, busy});
        end
        nxt();
        tick();
        checks++;
        if ({if_rvalid, busy} !== 2'b00) begin
            errors++; $display("FAIL fetch_idle_c4 got %b required 00", {if_rvalid, busy});
        end
    endtask

    task automatic test_contention();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
        tick();
        checks++;
        if ({dm_gnt, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie1_gnt got dm=%b if=%b required dm=1 if=0", dm_gnt, if_gnt);
        end
        expect_resp(1'b1, 32'hA5A5_0001, 1'b0);
        // DM keeps requesting (new address) so the next IDLE cycle is again a tie.
        nxt(); dm_addr = 32'h104; mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick();
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== '0 || mem_be !== 4'hF || {if_gnt, dm_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL tie1_mem got addr=%h wd=%h be=%h gnt=%b required 00000100 00000000 f 00",
                     mem_addr, mem_wdata, mem_be, {if_gnt, dm_gnt});
        end
        nxt(); mem_ready = 1'b0;
        tick();
        checks++;
        if ({dm_rvalid, if_gnt, dm_gnt} !== 3'b100) begin
            errors++; $display("FAIL tie1_resp got %b required 100", {dm_rvalid, if_gnt, dm_gnt});
        end
        nxt();
        tick();
        checks++;
        if ({if_gnt, dm_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie2_gnt got if=%b dm=%b required if=1 dm=0", if_gnt, dm_gnt);
        end
        expect_resp(1'b0, 32'h1111_2222, 1'b0);
        nxt(); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        checks++;
        if (mem_addr !== 32'h40) begin errors++; $display("FAIL tie2_mem_addr got %h required 00000040", mem_addr); end
        nxt(); mem_ready = 1'b0;
        tick();
        checks++;
        if ({if_rvalid, dm_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie2_resp got %b required 10", {if_rvalid, dm_gnt});
        end
        nxt();
        tick();
        checks++;
        if (dm_gnt !== 1'b1) begin errors++; $display("FAIL b2b_dm_gnt got %b required 1", dm_gnt); end
        expect_resp(1'b1, 32'h3333_4444, 1'b0);
        nxt(); dm_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        tick();
        checks++;
        if (mem_addr !== 32'h104) begin errors++; $display("FAIL b2b_mem_addr got %h required 00000104", mem_addr); end
        nxt(); mem_ready = 1'b0;
        tick();
        checks++;
        if (dm_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_resp got %b required 1", dm_rvalid); end
        nxt(); clear_inputs();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h204; dm_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        checks++;
        if ({dm_gnt, mem_req} !== 2'b10 || mem_wdata !== '0) begin
            errors++; $display("FAIL store_gnt got gnt=%b req=%b wd=%h required 1 0 00000000", dm_gnt, mem_req, mem_wdata);
        end
        expect_resp(1'b1, 32'h0, 1'b0);
        nxt(); dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b110011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h204) begin
            errors++;
            $display("FAIL store_mem got req=%b we=%b be=%b wd=%h addr=%h required 1 1 0011 deadbeef 00000204",
                     mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        nxt();
        tick();
        checks++;
        if ({dm_rvalid, mem_req, mem_we} !== 3'b100 || mem_wdata !== '0) begin
            errors++; $display("FAIL store_resp got %b wd=%h required 100 00000000", {dm_rvalid, mem_req, mem_we}, mem_wdata);
        end
        nxt();
        tick();
        checks++;
        if ({dm_rvalid, busy, mem_req} !== 3'b000) begin
            errors++; $display("FAIL store_idle got %b required 000", {dm_rvalid, busy, mem_req});
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            nxt(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300 + 32'(v * 4); mem_ready = 1'b0;
            tick();
            checks++;
            if (dm_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt%0d got %b required 1", v, dm_gnt); end
            expect_resp(1'b1, (v == 1) ? 32'h0BAD_F00D : 32'h0, (v == 1) ? 1'b0 : 1'b1);
            nxt(); dm_req = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                if (v == 1 && c == 4) begin mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; end
                tick();
                checks++;
                if ({mem_req, dm_rvalid} !== 2'b10) begin
                    errors++; $display("FAIL to_hold%0d_c%0d got %b required 10", v, c, {mem_req, dm_rvalid});
                end
                nxt();
            end
            mem_ready = 1'b0; mem_rdata = '0;
            tick();
            checks++;
            if ({mem_req, dm_rvalid} !== 2'b01) begin
                errors++; $display("FAIL to_resp%0d got %b required 01", v, {mem_req, dm_rvalid});
            end
            nxt();
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        nxt(); if_req = 1'b1; if_addr = 32'h500;
        tick();
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmb_gnt got %b required 1", if_gnt); end
        expect_resp(1'b0, 32'h0, 1'b0);
        nxt(); if_req = 1'b0;
        tick();
        nxt();
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rmb_req_c2 got %b required 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, if_gnt} !== 3'b000) begin
            errors++; $display("FAIL rmb_async_drop got %b required 000", {mem_req, busy, if_gnt});
        end
        sb.delete();
        tick();
        nxt();
        tick();
        nxt(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({if_rvalid, dm_rvalid, mem_req} !== 3'b000) begin
                errors++; $display("FAIL rmb_quiet_c%0d got %b required 000", c, {if_rvalid, dm_rvalid, mem_req});
            end
            nxt();
        end
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        checks++;
        if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmb_regrant got %b required 1", if_gnt); end
        expect_resp(1'b0, 32'hCAFE_0600, 1'b0);
        nxt(); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_0600;
        tick();
        checks++;
        if (mem_addr !== 32'h600) begin errors++; $display("FAIL rmb_mem_addr got %h required 00000600", mem_addr); end
        nxt(); mem_ready = 1'b0;
        tick();
        checks++;
        if (if_rvalid !== 1'b1) begin errors++; $display("FAIL rmb_resp got %b required 1", if_rvalid); end
        nxt();
        tick();
        clear_inputs();
    endtask

    task automatic test_withdrawn();
        nxt(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
        tick();
        checks++;
        if (dm_gnt !== 1'b1) begin errors++; $display("FAIL wd_dm_gnt got %b required 1", dm_gnt); end
        expect_resp(1'b1, 32'h7777_0000, 1'b0);
        nxt(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h800;
        tick();
        checks++;
        if (if_gnt !== 1'b0 || mem_addr !== 32'h700) begin
            errors++; $display("FAIL wd_busy_c1 got gnt=%b addr=%h required 0 00000700", if_gnt, mem_addr);
        end
        nxt(); if_req = 1'b0; if_addr = '0; mem_ready = 1'b1; mem_rdata = 32'h7777_0000;
        tick();
        checks++;
        if (if_gnt !== 1'b0 || mem_addr !== 32'h700) begin
            errors++; $display("FAIL wd_busy_c2 got gnt=%b addr=%h required 0 00000700", if_gnt, mem_addr);
        end
        nxt(); mem_ready = 1'b0;
        tick();
        checks++;
        if ({dm_rvalid, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL wd_resp got %b required 10", {dm_rvalid, if_gnt});
        end
        for (int c = 0; c < 2; c++) begin
            nxt();
            tick();
            checks++;
            if ({mem_req, if_gnt, busy} !== 3'b000) begin
                errors++; $display("FAIL wd_idle_c%0d got %b required 000", c, {mem_req, if_gnt, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        test_withdrawn();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drained got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit got still running required finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch requester and the data load/store requester, so the CPU can run from one memory array instead of separate instruction and data memories. It sits between the fetch/data-access stages and the memory port. It serialises one transaction at a time, arbitrates round-robin on contention, and returns responses to the owning requester. A watchdog terminates any access the memory fails to acknowledge.

## Interface
- TIMEOUT, 255: maximum cycles `mem_req` is held waiting for `mem_ready`; 0 disables the watchdog.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: fetch response valid.
- if_rdata  out  32  fetched word, valid with `if_rvalid`.
- if_err  out  1  fetch timed out, valid with `if_rvalid`.
- dm_req  in  1  data request; held with the other `dm_*` inputs stable until `dm_gnt`.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  store byte enables.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  one-cycle pulse: data request accepted.
- dm_rvalid  out  1  one-cycle pulse: data response (load data or store ack).
- dm_rdata  out  32  load data; 0 for stores and errors.
- dm_err  out  1  data access timed out, valid with `dm_rvalid`.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables; 4'hF for fetches and loads.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data; 0 for reads.
- mem_ready  in  1  memory completes the access this cycle; `mem_rdata` valid.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in BUSY and RESP.

## Operation
- Single clock `clk`; asynchronous active-low reset `rst_n`.
- States: IDLE, BUSY, RESP. Registers:
  - `owner` (IF/DM)
  - `last` (last granted requester)
  - the captured request fields
  - the timeout counter, width clog2(TIMEOUT+1)
- IDLE:
  - With only one request present, grant that request.
  - With both present, grant the requester that is not `last`.
  - Grant is combinational from `*_req`; `*_gnt` is high in that IDLE cycle.
  - At the clock edge: capture addr/we/be/wdata, set `owner` and `last`, clear the counter, go to BUSY.
  - With no request present, stay in IDLE.
- BUSY:
  - `mem_*` are driven from the captured registers; `mem_req` = 1.
  - If `mem_ready` = 1: capture `mem_rdata` (forced to 0 for writes), err = 0, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: capture rdata = 0, err = 1, go to RESP.
  - Else: counter++.
- RESP:
  - `owner`'s `*_rvalid` = 1, with `*_rdata` and `*_err` from the registers.
  - The other requester's `rvalid` = 0.
  - Go to IDLE. No grant is issued in RESP.
- `mem_ready` is ignored outside BUSY.
- A request dropped before its grant is legal; nothing is issued.
- `*_rdata` and `*_err` hold their last value between pulses and are meaningful only with `rvalid`.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `last` = IF (the first tie goes to DM), counter = 0.
  - All outputs 0, including `mem_req`; `*_gnt` is 0 while `rst_n` is low.
- Reset mid-BUSY aborts the access: `mem_req` drops without waiting for the clock, and no response is issued.
- Latency with `*_gnt` in cycle 0:
  - `mem_req` is high from cycle 1.
  - With `mem_ready` in cycle k ≥ 1, `rvalid` is in cycle k+1.
  - Minimum request-to-response is 2 cycles. Minimum back-to-back grants are 3 cycles apart.
- Timeout: `mem_req` stays high exactly TIMEOUT cycles (cycles 1..TIMEOUT), with the err response in cycle TIMEOUT+1.
- `mem_ready` high in the final timeout cycle counts as success; ready wins over timeout.
- `mem_*` outputs are stable for the whole BUSY interval and are 0 outside BUSY.

## Test plan
- Fetch only: `if_req` with `if_addr` = 0x0000_0010; memory asserts ready 1 cycle after `mem_req` with rdata 0x0010_0093. Required: `if_gnt` in cycle 0, `mem_req` cycles 1–2, `if_rvalid` in cycle 3 with `if_rdata` = 0x0010_0093 and `if_err` = 0.
- Contention after reset: `if_req` and `dm_req` (load at 0x100) both rise in the same cycle. Required: DM is granted first; IF is granted in the IDLE cycle after the DM response; a second simultaneous pair grants IF first.
- Store: `dm_we` = 1, `dm_be` = 4'b0011, `dm_addr` = 0x204, `dm_wdata` = 0xDEAD_BEEF, with `mem_ready` held high. Required: `mem_we` = 1, `mem_be` = 0011, `mem_wdata` = 0xDEAD_BEEF for one cycle; `dm_rvalid` next cycle with `dm_rdata` = 0.
- Timeout with TIMEOUT = 4 and `mem_ready` held 0. Required: `mem_req` high exactly 4 cycles, then `dm_rvalid` = 1 with `dm_err` = 1 and `dm_rdata` = 0. A repeat with `mem_ready` = 1 in the 4th cycle returns err = 0.
- Reset mid-BUSY: assert `rst_n` = 0 asynchronously during the 2nd cycle of `mem_req`. Required: `mem_req` drops immediately, no `rvalid` is issued, and after release a new `if_req` is granted normally.
- Withdrawn request: `if_req` pulses for 1 cycle while a DM access is BUSY. Required: no fetch grant and no `mem_req` for that fetch.
